lcd_update_arbiter: RTL
=======================

Name: lcd_update_arbiter

Overview:
- Shares the single LCD driver between several game blocks, e.g. the reaction timer, a score tracker and an attract-mode banner.
- Each requester raises an update request carrying a message code. The arbiter grants requesters round-robin, forwards the message to the LCD driver over the Update/Ack handshake and returns a 4-phase acknowledge to the requester.
- It sits between the game FSMs and the LCD driver, and includes a timeout so a dead driver cannot hang the game.

Parameters:
- N_REQ, 4: number of requesters; must be 2..8.
- MSG_W, 4: width of one message code.
- TIMEOUT, 50000: maximum cycles to wait for LCDAck before the transaction is abandoned; must be at least 2.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- ReqUpdate  input  N_REQ  per-requester update request; the requester holds it high until it sees its ReqAck.
- ReqMsg  input  N_REQ*MSG_W  message codes; requester i uses bits [i*MSG_W +: MSG_W].
- ReqAck  output  N_REQ  per-requester acknowledge (4-phase).
- Grant  output  N_REQ  one-hot; identifies the requester currently being served.
- LCDUpdate  output  1  update strobe to the LCD driver.
- LCDMsg  output  MSG_W  message code to the LCD driver; stable while LCDUpdate is high.
- LCDAck  input  1  acknowledge from the LCD driver.
- Busy  output  1  high when the arbiter is in any state other than IDLE.
- Timeout  output  1  one-cycle pulse when a transaction is abandoned.

Behaviour:
- Reset (Rst=0, takes effect immediately, no clock needed):
  - state = IDLE, round-robin pointer Ptr = 0, latched index = 0, timeout counter = 0.
  - Outputs ReqAck, Grant, LCDUpdate, LCDMsg and Timeout are all 0.
- States: IDLE, WAIT_ACK, RELEASE. All outputs are registered.
- IDLE:
  - Starts a transaction when any ReqUpdate bit is 1 and LCDAck == 0.
  - Winner = first set bit searching upward from Ptr, wrapping N_REQ-1 to 0.
  - At that edge: latch the winner index and its ReqMsg into LCDMsg, set Grant one-hot, set LCDUpdate = 1, clear the counter, go to WAIT_ACK.
  - If LCDAck == 1, no transaction starts even with requests pending; the driver must return low first.
  - Latency: ReqUpdate sampled at edge k gives LCDUpdate high after edge k.
- WAIT_ACK:
  - LCDUpdate, LCDMsg and Grant are held; the counter increments every cycle.
  - LCDAck sampled 1: LCDUpdate <= 0, ReqAck[idx] <= 1, go to RELEASE.
  - Otherwise, if counter == TIMEOUT-1: LCDUpdate <= 0, ReqAck[idx] <= 1, Timeout <= 1 for one cycle, go to RELEASE.
  - If LCDAck and the timeout occur in the same cycle, LCDAck wins and no Timeout pulse is produced.
  - If ReqUpdate[idx] drops early, it is ignored: the message is already latched and the transaction completes.
- RELEASE:
  - ReqAck[idx] is held high until ReqUpdate[idx] is sampled 0.
  - At that edge: ReqAck <= 0, Grant <= 0, Ptr <= (idx+1) mod N_REQ, go to IDLE.
- Requests from other requesters arriving while Busy stay pending; nothing is dropped or queued beyond the level-held ReqUpdate.
- Fairness: a requester that re-requests immediately after release is served only after every other pending requester.
- The next transaction can start at the earliest one cycle after the return to IDLE, i.e. no back-to-back overlap.
- LCDMsg keeps its last value outside transactions. Only ReqAck[idx], at most one bit, is ever set.

Decomposition:
- Shared package lcd_arb_pkg holds:
  - state encoding constants ST_IDLE = 0, ST_WAIT_ACK = 1, ST_RELEASE = 2;
  - default N_REQ, MSG_W and TIMEOUT;
  - the message code constants used across the game: MSG_READY, MSG_WAIT, MSG_CHEAT, MSG_SLOW, MSG_TIME.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: request vector and Ptr. Outputs: valid, winner index, one-hot winner. It is instantiated once in IDLE.

Test Plan:
1. Single requester, normal handshake:
   - Stimulus: ReqUpdate = 0001, ReqMsg[0] = 4'h3; driver asserts LCDAck 3 cycles after LCDUpdate rises, for 1 cycle.
   - Required: LCDMsg = 3 and Grant = 0001 throughout; LCDUpdate falls the edge after LCDAck; ReqAck[0] stays high until ReqUpdate[0] drops; Ptr becomes 1.
2. All requesters at once:
   - Stimulus: immediately after reset, ReqUpdate = 1111 with messages 1, 2, 3, 4.
   - Required: LCD sees messages 1, 2, 3, 4 in order; exactly one Grant bit high at any time; Busy low for at least one cycle between transactions.
3. Round-robin fairness:
   - Stimulus: requesters 1 and 2 re-request immediately after each release.
   - Required: grant order 1, 2, 1, 2; neither is granted twice in a row.
4. Timeout:
   - Stimulus: TIMEOUT = 16, driver never acks.
   - Required: LCDUpdate high for exactly 16 cycles, then low; Timeout pulses for 1 cycle; ReqAck asserted; the arbiter returns to IDLE after the requester releases.
5. Stuck driver ack:
   - Stimulus: LCDAck held 1 while in IDLE with ReqUpdate = 0100.
   - Required: LCDUpdate stays 0 until LCDAck falls; the transaction then starts on the next edge.
6. Reset mid-transaction:
   - Stimulus: Rst driven low during WAIT_ACK, between clock edges.
   - Required: all outputs 0 immediately; after Rst returns high with ReqUpdate = 0110, requester 1 is served first (Ptr = 0).

Source files
------------

// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the LCD update arbiter: state encoding, default
// sizing and the message codes the game blocks send to the display.
package lcd_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_RELEASE  = 2'd2
   } arb_state_t;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_MSG_W   = 4;
   localparam int DEF_TIMEOUT = 50000;

   localparam logic [3:0] MSG_READY = 4'h1;
   localparam logic [3:0] MSG_WAIT  = 4'h2;
   localparam logic [3:0] MSG_CHEAT = 4'h3;
   localparam logic [3:0] MSG_SLOW  = 4'h4;
   localparam logic [3:0] MSG_TIME  = 4'h5;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from the top requester back to requester 0.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   always_comb begin
      int j;
      j      = 0;
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      // Walk from the farthest candidate down so the nearest one to ptr wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (req[j]) begin
            valid     = 1'b1;
            idx       = IDX_W'(j);
            onehot    = '0;
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_update_arbiter.sv
// Round-robin arbiter sharing one LCD driver between game blocks, with a
// 4-phase acknowledge back to each requester and a driver-ack timeout.
module lcd_update_arbiter
   import lcd_arb_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int MSG_W   = DEF_MSG_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [N_REQ-1:0]       ReqUpdate,
   input  logic [N_REQ*MSG_W-1:0] ReqMsg,
   output logic [N_REQ-1:0]       ReqAck,
   output logic [N_REQ-1:0]       Grant,
   output logic                   LCDUpdate,
   output logic [MSG_W-1:0]       LCDMsg,
   input  logic                   LCDAck,
   output logic                   Busy,
   output logic                   Timeout
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   // Requester side: ReqUpdate is a level held until ReqAck is seen, and
   // ReqAck is held until ReqUpdate drops. Driver side: LCDUpdate is held
   // with a stable LCDMsg until LCDAck is sampled high or the wait expires.
   arb_state_t       state, state_d;
   logic [IDX_W-1:0] ptr, ptr_d, idx, idx_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [N_REQ-1:0] req_ack, req_ack_d, grant, grant_d;
   logic             lcd_update, lcd_update_d, timeout_q, timeout_d;
   logic [MSG_W-1:0] lcd_msg, lcd_msg_d;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [N_REQ-1:0] pick_onehot;
   logic             start, cnt_hit, released;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req    (ReqUpdate),
      .ptr    (ptr),
      .valid  (pick_valid),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign start    = (state == ST_IDLE) && pick_valid && !LCDAck;
   assign cnt_hit  = (cnt == CNT_W'(TIMEOUT - 1));
   assign released = !ReqUpdate[idx];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         idx        <= '0;
         cnt        <= '0;
         req_ack    <= '0;
         grant      <= '0;
         lcd_update <= 1'b0;
         lcd_msg    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_d;
         ptr        <= ptr_d;
         idx        <= idx_d;
         cnt        <= cnt_d;
         req_ack    <= req_ack_d;
         grant      <= grant_d;
         lcd_update <= lcd_update_d;
         lcd_msg    <= lcd_msg_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:     if (start) state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: if (LCDAck || cnt_hit) state_d = ST_RELEASE;
         ST_RELEASE:  if (released) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ptr_d        = ptr;
      idx_d        = idx;
      cnt_d        = cnt;
      req_ack_d    = req_ack;
      grant_d      = grant;
      lcd_update_d = lcd_update;
      lcd_msg_d    = lcd_msg;
      timeout_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               idx_d        = pick_idx;
               lcd_msg_d    = ReqMsg[int'(pick_idx)*MSG_W +: MSG_W];
               grant_d      = pick_onehot;
               lcd_update_d = 1'b1;
               cnt_d        = '0;
            end
         end
         ST_WAIT_ACK: begin
            cnt_d = cnt + 1'b1;
            // A real ack in the expiry cycle takes priority over the timeout.
            if (LCDAck || cnt_hit) begin
               lcd_update_d   = 1'b0;
               req_ack_d      = '0;
               req_ack_d[idx] = 1'b1;
               timeout_d      = !LCDAck;
            end
         end
         ST_RELEASE: begin
            if (released) begin
               req_ack_d = '0;
               grant_d   = '0;
               ptr_d     = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign ReqAck    = req_ack;
   assign Grant     = grant;
   assign LCDUpdate = lcd_update;
   assign LCDMsg    = lcd_msg;
   assign Timeout   = timeout_q;
   assign Busy      = (state != ST_IDLE);

endmodule
